prop_sweep_ctrl: RTL

Sequencer that drives the shared CHERI capability property-check bank (base/len/addr/newBase/newLen → per-property ok bits) with a deterministic stream of 32-bit test vectors. It issues one vector per cycle, then samples the bank's per-property results after a fixed latency. It counts masked failures and records the first failing vector index, so a failure can be reproduced from SEED. It sits between a testbench/SoC control register block and the property bank, turning the combinational assertion checkers into a reproducible, self-checking sweep.

---
 rtl/prop_sweep_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/prop_sweep_ctrl.sv
// prop_sweep_ctrl: drives the capability property-check bank with a reproducible
// stream of test vectors (four directed corners, then LFSR-derived), samples the
// bank's per-property results LAT cycles later and records masked failures.
module prop_sweep_ctrl #(
    parameter int          LAT   = 1,
    parameter int          NPROP = 8,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [31:0]      count,
    input  logic [NPROP-1:0] prop_mask,
    output logic             busy,
    output logic             done,
    output logic             vec_valid,
    output logic [31:0]      vec_base,
    output logic [31:0]      vec_len,
    output logic [31:0]      vec_addr,
    output logic [31:0]      vec_newBase,
    output logic [31:0]      vec_newLen,
    input  logic [NPROP-1:0] prop_ok,
    output logic [31:0]      fail_count,
    output logic             first_fail_valid,
    output logic [31:0]      first_fail_idx,
    output logic [NPROP-1:0] first_fail_props
);

    localparam logic [31:0] TAPS       = 32'h8020_0003;
    // Pipeline storage is at least one stage deep so LAT=0 still elaborates;
    // with LAT=0 the live vector tag is used directly instead.
    localparam int          PW         = (LAT == 0) ? 1 : LAT;
    localparam logic [2:0]  DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_count;
    logic [NPROP-1:0]   r_mask;
    logic [31:0]        r_idx;
    logic [31:0]        r_lfsr;
    logic [2:0]         r_drain;

    logic [PW-1:0]      r_pv;
    logic [31:0]        r_pidx [PW];

    logic [31:0]        r_fail_count;
    logic               r_ff_valid;
    logic [31:0]        r_ff_idx;
    logic [NPROP-1:0]   r_ff_props;

    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_lfsr_nxt;
    logic [31:0]        w_rot16;
    logic [31:0]        w_rot8;
    logic [31:0]        w_b;
    logic [31:0]        w_l;
    logic [31:0]        w_a;
    logic [31:0]        w_nb;
    logic [31:0]        w_nl;
    logic               w_al_v;
    logic [31:0]        w_al_idx;
    logic [NPROP-1:0]   w_fbits;
    logic               w_fail;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_idx == r_count - 32'd1);
    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'd0);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and status outputs
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        vec_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (count == 32'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                vec_valid = 1'b1;
                if (w_last) w_next = (LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drain == 3'd0) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run bookkeeping: latched run parameters, vector index, LFSR, drain timer
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= 32'd0;
            r_mask  <= '0;
            r_idx   <= 32'd0;
            r_lfsr  <= SEED;
            r_drain <= 3'd0;
        end else if (w_accept) begin
            r_count <= count;
            r_mask  <= prop_mask;
            r_idx   <= 32'd0;
            r_lfsr  <= SEED;
        end else if (r_state == S_ISSUE) begin
            r_idx <= r_idx + 32'd1;
            // Directed corners do not consume LFSR states
            if (r_idx >= 32'd4) r_lfsr <= w_lfsr_nxt;
            if (w_last)         r_drain <= DRAIN_INIT;
        end else if (r_state == S_DRAIN) begin
            r_drain <= r_drain - 3'd1;
        end
    end

    // Vector generation: directed corners for idx 0..3, LFSR-derived after
    always_comb begin
        w_rot16 = {r_lfsr[15:0], r_lfsr[31:16]};
        w_rot8  = {r_lfsr[23:0], r_lfsr[31:24]};
        w_b     = r_lfsr;
        w_l     = w_rot16 >> r_lfsr[4:0];
        w_a     = r_lfsr + (w_rot8 >> r_lfsr[9:5]);
        w_nb    = r_lfsr + (r_lfsr >> r_lfsr[14:10]);
        w_nl    = w_l >> 1;
        case (r_idx)
            32'd0: begin
                w_b = 32'h0; w_l = 32'h0; w_a = 32'h0; w_nb = 32'h0; w_nl = 32'h0;
            end
            32'd1: begin
                w_b = 32'h0; w_l = 32'hFFFF_FFFF; w_a = 32'hFFFF_FFFF;
                w_nb = 32'h0; w_nl = 32'hFFFF_FFFF;
            end
            32'd2: begin
                w_b = 32'hFFFF_FFFF; w_l = 32'h1; w_a = 32'h0;
                w_nb = 32'hFFFF_FFFF; w_nl = 32'h0;
            end
            32'd3: begin
                w_b = 32'h8000_0000; w_l = 32'h8000_0000; w_a = 32'h7FFF_FFFF;
                w_nb = 32'h8000_0000; w_nl = 32'h1;
            end
            default: ;
        endcase
    end

    assign vec_base    = vec_valid ? w_b  : 32'd0;
    assign vec_len     = vec_valid ? w_l  : 32'd0;
    assign vec_addr    = vec_valid ? w_a  : 32'd0;
    assign vec_newBase = vec_valid ? w_nb : 32'd0;
    assign vec_newLen  = vec_valid ? w_nl : 32'd0;

    // Result tag pipeline: carries {valid, idx} to line up with prop_ok
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pv <= '0;
            for (int i = 0; i < PW; i++) r_pidx[i] <= 32'd0;
        end else begin
            r_pv[0]   <= vec_valid;
            r_pidx[0] <= r_idx;
            for (int i = 1; i < PW; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pidx[i] <= r_pidx[i-1];
            end
        end
    end

    assign w_al_v   = (LAT == 0) ? vec_valid : r_pv[PW-1];
    assign w_al_idx = (LAT == 0) ? r_idx     : r_pidx[PW-1];
    assign w_fbits  = ~prop_ok & r_mask;
    assign w_fail   = w_al_v && (|w_fbits);

    // Failure recording: saturating count plus first failing vector
    always_ff @(posedge CLK) begin
        if (RST || w_accept) begin
            r_fail_count <= 32'd0;
            r_ff_valid   <= 1'b0;
            r_ff_idx     <= 32'd0;
            r_ff_props   <= '0;
        end else if (w_fail) begin
            if (r_fail_count != 32'hFFFF_FFFF) r_fail_count <= r_fail_count + 32'd1;
            if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_idx   <= w_al_idx;
                r_ff_props <= w_fbits;
            end
        end
    end

    assign fail_count       = r_fail_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;
    assign first_fail_props = r_ff_props;

endmodule
